// File: rtl/bist_controller.sv
// Logic-BIST sequencer: clears the MISR, runs the TPG for NUM_PATTERNS cycles,
// lines MISR compaction up with the CUT latency, then captures and grades the signature.
module bist_controller #(
  parameter int unsigned NUM_PATTERNS = 256,
  parameter int unsigned CUT_LATENCY  = 0,
  parameter logic [15:0] GOLDEN_SIG   = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] misr_sig,
  output logic        misr_reset,
  output logic        misr_enable,
  output logic        tpg_enable,
  output logic [15:0] pattern_count,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, FLUSH, COMPARE, DONE} state_e;

  localparam logic [15:0] LAST_CNT   = 16'(NUM_PATTERNS - 1);
  localparam logic [3:0]  FLUSH_LAST = 4'((CUT_LATENCY > 0) ? (CUT_LATENCY - 1) : 0);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  lat_q, lat_d;
  logic [15:0] sig_q, sig_d;
  logic        pass_q, pass_d;
  logic        misr_reset_q, tpg_en_q, misr_en_q, busy_q, done_q;
  logic        tpg_en_d, misr_en_d, men_raw, pipe_flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    sig_d   = sig_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        state_d = abort ? IDLE : RUN;
      end
      RUN: begin
        // The count advances on every RUN cycle, including one that is aborted.
        cnt_d = cnt_q + 16'd1;
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == LAST_CNT) begin
          state_d = (CUT_LATENCY > 0) ? FLUSH : COMPARE;
          lat_d   = FLUSH_LAST;
        end
      end
      FLUSH: begin
        if (abort) begin
          state_d = IDLE;
        end else if (lat_q == 4'd0) begin
          state_d = COMPARE;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      COMPARE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          sig_d   = misr_sig;
          pass_d  = (misr_sig == GOLDEN_SIG);
          state_d = DONE;
        end
      end
      DONE: begin
        if (start && !abort) begin
          state_d = CLEAR;
          cnt_d   = '0;
          sig_d   = '0;
          pass_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tpg_en_d   = (state_d == RUN);
  assign pipe_flush = (state_d == CLEAR) || (state_d == IDLE);
  assign misr_en_d  = men_raw && ((state_d == RUN) || (state_d == FLUSH));

  // The pipe is fed with the next-cycle TPG enable so that the registered
  // misr_enable lands exactly CUT_LATENCY cycles behind the registered tpg_enable.
  if (CUT_LATENCY == 0) begin : g_nopipe
    assign men_raw = tpg_en_d;
  end else begin : g_pipe
    logic [CUT_LATENCY-1:0] pipe_q;
    logic [CUT_LATENCY:0]   ext;
    assign ext     = {pipe_q, tpg_en_d};
    assign men_raw = ext[CUT_LATENCY];
    always_ff @(posedge clk) begin
      if (reset || pipe_flush) begin
        pipe_q <= '0;
      end else begin
        pipe_q <= ext[CUT_LATENCY-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      lat_q        <= '0;
      sig_q        <= '0;
      pass_q       <= 1'b0;
      misr_reset_q <= 1'b0;
      tpg_en_q     <= 1'b0;
      misr_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lat_q        <= lat_d;
      sig_q        <= sig_d;
      pass_q       <= pass_d;
      misr_reset_q <= (state_d == CLEAR);
      tpg_en_q     <= tpg_en_d;
      misr_en_q    <= misr_en_d;
      busy_q       <= (state_d == CLEAR) || (state_d == RUN) ||
                      (state_d == FLUSH) || (state_d == COMPARE);
      done_q       <= (state_d == DONE);
    end
  end

  assign misr_reset    = misr_reset_q;
  assign misr_enable   = misr_en_q;
  assign tpg_enable    = tpg_en_q;
  assign pattern_count = cnt_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign signature     = sig_q;

endmodule

// File: doc/bist_controller.md
# bist_controller

Sequencing controller for the 16-bit signature-analysis MISR in the logic-BIST path. On a start request it clears the MISR, runs the test-pattern generator for a fixed pattern count, and gates MISR compaction to line up with the circuit-under-test latency. It then captures the final signature, compares it against a golden value and reports pass/fail. It sits between the top-level test access logic and the TPG/CUT/MISR chain.

## Interface
- NUM_PATTERNS, 256: number of patterns applied; legal range 1..65535.
- CUT_LATENCY, 0: pipeline depth, in cycles, from TPG output to MISR serial input; legal range 0..15.
- GOLDEN_SIG, 16'h0000: expected final MISR signature.
- clk  in  1  rising-edge clock, shared with TPG and MISR.
- reset  in  1  synchronous active-high reset.
- start  in  1  one-cycle request to begin a BIST run; honoured only in IDLE or DONE.
- abort  in  1  terminates a run in progress; returns to IDLE.
- misr_sig  in  16  current MISR contents.
- misr_reset  out  1  synchronous clear to the MISR.
- misr_enable  out  1  MISR shift/compact enable.
- tpg_enable  out  1  TPG advance enable; one pattern per cycle while high.
- pattern_count  out  16  patterns issued so far in the current run.
- busy  out  1  high in CLEAR, RUN, FLUSH and COMPARE.
- done  out  1  high in DONE.
- pass  out  1  result of the comparison; valid while done is high.
- signature  out  16  captured final signature; valid while done is high.

## Operation
- States: IDLE, CLEAR, RUN, FLUSH, COMPARE, DONE.
- Reset values: state=IDLE; all outputs 0; signature=16'h0000; pattern_count=0.
- IDLE + start goes to CLEAR. DONE + start also goes to CLEAR, and clears done, pass and signature on entry.
- CLEAR lasts exactly 1 cycle:
  - misr_reset=1.
  - pattern_count reset to 0.
  - Next state RUN.
- RUN:
  - tpg_enable=1.
  - pattern_count increments on every cycle spent in RUN.
  - When the count reaches NUM_PATTERNS, leave tpg_enable low from the next cycle.
  - Go to FLUSH if CUT_LATENCY>0, otherwise to COMPARE.
- FLUSH lasts exactly CUT_LATENCY cycles, with tpg_enable=0. An internal latency counter counts down.
- misr_enable is tpg_enable delayed by exactly CUT_LATENCY cycles through a shift pipe:
  - It is high for exactly NUM_PATTERNS cycles per run.
  - It is forced to 0 in CLEAR, COMPARE, DONE and IDLE.
  - The delay pipe is flushed when CLEAR is entered.
- COMPARE lasts 1 cycle:
  - signature <= misr_sig.
  - pass <= (misr_sig == GOLDEN_SIG).
  - Next state DONE.
- DONE holds done, pass, signature and pattern_count until start, or until reset is asserted.
- start in CLEAR, RUN, FLUSH or COMPARE is ignored.
- abort in CLEAR, RUN, FLUSH or COMPARE:
  - Next state IDLE.
  - tpg_enable, misr_enable and the delay pipe are cleared the next cycle.
  - done and pass stay 0; pattern_count holds its last value.
- abort in IDLE or DONE has no effect.
- abort and start in the same cycle: abort wins.
- reset mid-run: everything returns to reset values on the next edge; no partial result is reported.

## Timing
- The cycle where start is sampled high in IDLE is cycle 0; L = CUT_LATENCY, N = NUM_PATTERNS.
- Cycle 1: CLEAR, misr_reset=1, busy=1.
- Cycles 2..N+1: RUN, tpg_enable=1. pattern_count reads k-1 during cycle k+1 and reaches N at cycle N+2.
- Cycles 2+L..N+1+L: misr_enable=1.
- Cycles N+2..N+1+L: FLUSH (absent when L=0).
- Cycle N+2+L: COMPARE. misr_sig already includes all N compactions.
- Cycle N+3+L onward: DONE, busy=0, done=1, pass and signature valid.
- Total latency from start to done is N+3+L cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- N=4, L=0, GOLDEN_SIG equal to the MISR result of a known TPG stream; pulse start at cycle 0:
  - misr_reset high at cycle 1 only.
  - tpg_enable and misr_enable high during cycles 2-5.
  - done=1 at cycle 7 with pass=1 and signature equal to GOLDEN_SIG.
- Same run with GOLDEN_SIG XOR 16'h0001 -> done=1 at cycle 7, pass=0, signature unchanged from the previous case.
- N=4, L=2:
  - tpg_enable high during cycles 2-5; misr_enable high during cycles 4-7.
  - FLUSH during cycles 6-7; done=1 at cycle 9.
  - Exactly 4 misr_enable cycles.
- N=8; start pulsed again at cycle 4, then abort at cycle 6:
  - The second start has no effect.
  - State is IDLE at cycle 7; tpg_enable and misr_enable are 0 from cycle 7.
  - done=0 and pattern_count=5 held.
- From DONE with pass=1, pulse start:
  - done, pass and signature clear the next cycle.
  - misr_reset pulses; a full second run completes with identical timing.
- reset asserted at cycle 3 of an N=4 run -> all outputs 0 the next cycle, state IDLE; a later start runs normally.
